// File: rtl/turn_sequencer.sv
// turn_sequencer: game-flow controller for the guessing game.
// Turns synchronized active-low pushbuttons into single-cycle presses, validates
// and latches the human move, kicks the compute/compare datapath and waits for
// it with a timeout, counts rounds, and reports win / loss / datapath error.
//
// Datapath handshake: load_h is a one-cycle strobe telling the datapath to
// capture h_move. One cycle later c_start is a one-cycle strobe that starts the
// computer move and compare. The datapath answers by raising c_done. win is
// sampled one cycle after c_done is seen. c_done is only honoured while in
// COMPUTE, and it may already be high in the same cycle as c_start.
module turn_sequencer #(
    parameter int MAX_ROUNDS = 8,   // rounds allowed before loss (1..15)
    parameter int MAX_MOVE   = 9,   // largest legal move value
    parameter int TIMEOUT    = 200  // COMPUTE cycles allowed before error (2..1023)
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       newGame_L,
    input  logic       enter_L,
    input  logic [3:0] hMove,
    input  logic       c_done,
    input  logic       win,
    output logic       load_h,
    output logic [3:0] h_move,
    output logic       c_start,
    output logic [3:0] round,
    output logic       busy,
    output logic       bad_move,
    output logic       game_won,
    output logic       game_lost,
    output logic       error,
    output logic [2:0] dbg_state
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT_H  = 3'd1,
        LATCH   = 3'd2,
        COMPUTE = 3'd3,
        CHECK   = 3'd4,
        WON     = 3'd5,
        LOST    = 3'd6,
        ERR     = 3'd7
    } state_t;

    localparam int              CNT_W        = 10;
    localparam logic [3:0]      MAX_MOVE_C   = 4'(MAX_MOVE);
    localparam logic [3:0]      MAX_ROUNDS_C = 4'(MAX_ROUNDS);
    // Value the counter holds during the TIMEOUT-th COMPUTE cycle.
    localparam logic [CNT_W-1:0] LAST_CNT    = CNT_W'(TIMEOUT - 1);

    state_t             state_q, state_d;
    logic               enter_prev_q, new_prev_q;
    logic [3:0]         round_q, round_d;
    logic [3:0]         h_move_q, h_move_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               bad_move_q, bad_move_d;
    logic               load_h_q, c_start_q, busy_q;
    logic               won_q, lost_q, err_q;

    logic               enter_press, new_press;

    // A press is the first cycle a button is seen low after being high.
    assign enter_press = enter_prev_q & ~enter_L;
    assign new_press   = new_prev_q & ~newGame_L;

    // Next-state and datapath-register decisions; newGame overrides everything.
    always_comb begin
        state_d    = state_q;
        round_d    = round_q;
        h_move_d   = h_move_q;
        cnt_d      = cnt_q;
        bad_move_d = 1'b0;
        if (new_press) begin
            state_d = WAIT_H;
            round_d = 4'd0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                WAIT_H: begin
                    if (enter_press) begin
                        if (hMove <= MAX_MOVE_C) begin
                            state_d  = LATCH;
                            h_move_d = hMove;
                            round_d  = round_q + 4'd1;
                        end else begin
                            bad_move_d = 1'b1;
                        end
                    end
                end
                LATCH: begin
                    state_d = COMPUTE;
                    cnt_d   = '0;
                end
                COMPUTE: begin
                    // c_done takes precedence over an expiring timeout.
                    cnt_d = cnt_q + 1'b1;
                    if (c_done) begin
                        state_d = CHECK;
                    end else if (cnt_q == LAST_CNT) begin
                        state_d = ERR;
                    end
                end
                CHECK: begin
                    if (win) begin
                        state_d = WON;
                    end else if (round_q == MAX_ROUNDS_C) begin
                        state_d = LOST;
                    end else begin
                        state_d = WAIT_H;
                    end
                end
                // IDLE, WON, LOST and ERR only leave on newGame or reset.
                default: begin
                end
            endcase
        end
    end

    // State, button history and registered Moore outputs decoded from state_d.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            enter_prev_q <= 1'b1;
            new_prev_q   <= 1'b1;
            round_q      <= 4'd0;
            h_move_q     <= 4'd0;
            cnt_q        <= '0;
            bad_move_q   <= 1'b0;
            load_h_q     <= 1'b0;
            c_start_q    <= 1'b0;
            busy_q       <= 1'b0;
            won_q        <= 1'b0;
            lost_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            enter_prev_q <= enter_L;
            new_prev_q   <= newGame_L;
            round_q      <= round_d;
            h_move_q     <= h_move_d;
            cnt_q        <= cnt_d;
            bad_move_q   <= bad_move_d;
            load_h_q     <= (state_d == LATCH);
            c_start_q    <= (state_d == COMPUTE) && (state_q != COMPUTE);
            busy_q       <= (state_d == LATCH) || (state_d == COMPUTE) || (state_d == CHECK);
            won_q        <= (state_d == WON);
            lost_q       <= (state_d == LOST);
            err_q        <= (state_d == ERR);
        end
    end

    assign load_h    = load_h_q;
    assign h_move    = h_move_q;
    assign c_start   = c_start_q;
    assign round     = round_q;
    assign busy      = busy_q;
    assign bad_move  = bad_move_q;
    assign game_won  = won_q;
    assign game_lost = lost_q;
    assign error     = err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_turn_sequencer.sv
// Self-checking bench for turn_sequencer: directed game scenarios, with an
// event monitor comparing every strobe and terminal-status rise against an
// expected queue of {kind, value, cycle} words.
module tb_turn_sequencer;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WAIT_H = 3'd1;
    localparam logic [2:0] S_WON    = 3'd5;
    localparam logic [2:0] S_LOST   = 3'd6;
    localparam logic [2:0] S_ERR    = 3'd7;

    localparam int K_LOAD = 1;
    localparam int K_CST  = 2;
    localparam int K_BAD  = 3;
    localparam int K_WON  = 4;
    localparam int K_LOST = 5;
    localparam int K_ERR  = 6;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       newGame_L = 1'b1;
    logic       enter_L = 1'b1;
    logic [3:0] hMove = 4'd0;
    logic       c_done = 1'b0;
    logic       win = 1'b0;
    logic       load_h, c_start, busy, bad_move, game_won, game_lost, error;
    logic [3:0] h_move, round;
    logic [2:0] dbg_state;

    int         cyc = 0;
    int         errors = 0;
    int         checks = 0;
    int         exp_round = 0;
    logic [31:0] exp_q[$];

    turn_sequencer #(.MAX_ROUNDS(8), .MAX_MOVE(9), .TIMEOUT(200)) dut (
        .clock(clock), .reset(reset), .newGame_L(newGame_L), .enter_L(enter_L),
        .hMove(hMove), .c_done(c_done), .win(win), .load_h(load_h), .h_move(h_move),
        .c_start(c_start), .round(round), .busy(busy), .bad_move(bad_move),
        .game_won(game_won), .game_lost(game_lost), .error(error), .dbg_state(dbg_state)
    );

    // clock / reset / cycle index
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] ev(input int kind, input int val, input int c);
        return {4'(kind), 4'(val), 24'(c)};
    endfunction

    task automatic push(input int kind, input int val, input int c);
        exp_q.push_back(ev(kind, val, c));
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // scoreboard monitor
    logic won_p = 1'b0, lost_p = 1'b0, err_p = 1'b0;

    task automatic observe(input int kind, input logic [3:0] val);
        logic [31:0] got, exp;
        got = ev(kind, val, cyc);
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: actual=%0h required=none", got);
        end else begin
            exp = exp_q.pop_front();
            if (got !== exp) begin
                errors++;
                $display("FAIL event: actual=%0h required=%0h", got, exp);
            end
        end
    endtask

    always @(negedge clock) begin
        if (load_h === 1'b1)                       observe(K_LOAD, h_move);
        if (c_start === 1'b1)                      observe(K_CST, round);
        if (bad_move === 1'b1)                     observe(K_BAD, round);
        if (game_won === 1'b1 && won_p !== 1'b1)   observe(K_WON, round);
        if (game_lost === 1'b1 && lost_p !== 1'b1) observe(K_LOST, round);
        if (error === 1'b1 && err_p !== 1'b1)      observe(K_ERR, round);
        won_p  = game_won;
        lost_p = game_lost;
        err_p  = error;
    end

    // driver tasks (all entered and left at a negedge)
    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clock);
    endtask

    task automatic press_new();
        newGame_L = 1'b0;
        @(negedge clock);
        newGame_L = 1'b1;
        exp_round = 0;
    endtask

    task automatic tap_enter(input logic [3:0] mv);
        hMove   = mv;
        enter_L = 1'b0;
        @(negedge clock);
        enter_L = 1'b1;
    endtask

    // One accepted turn: d is the COMPUTE cycle index (0-based) holding c_done.
    task automatic do_turn(input logic [3:0] mv, input int d, input logic w);
        int t;
        t = cyc;
        exp_round++;
        push(K_LOAD, mv, t + 1);
        push(K_CST, exp_round, t + 2);
        if (w) push(K_WON, exp_round, t + 4 + d);
        else if (exp_round == 8) push(K_LOST, exp_round, t + 4 + d);
        tap_enter(mv);
        wait_until(t + 2 + d);
        c_done = 1'b1;
        win    = w;
        @(negedge clock);
        c_done = 1'b0;
        wait_until(t + 5 + d);
    endtask

    function automatic logic [6:0] status();
        return {load_h, c_start, busy, bad_move, game_won, game_lost, error};
    endfunction

    logic [3:0] mv_tab [8] = '{4'd0, 4'd9, 4'd1, 4'd8, 4'd2, 4'd7, 4'd4, 4'd6};

    initial begin
        int t;
        // reset state
        reset = 1'b1;
        repeat (3) @(negedge clock);
        check("reset_state", 32'(dbg_state), 32'(S_IDLE));
        check("reset_round", 32'(round), 0);
        check("reset_hmove", 32'(h_move), 0);
        check("reset_status", 32'(status()), 0);
        reset = 1'b0;
        @(negedge clock);

        // enter in IDLE is ignored
        tap_enter(4'd5);
        repeat (3) @(negedge clock);
        check("idle_ignores_enter", 32'(dbg_state), 32'(S_IDLE));

        press_new();
        check("newgame_state", 32'(dbg_state), 32'(S_WAIT_H));
        check("newgame_round", 32'(round), 0);
        check("newgame_status", 32'(status()), 0);

        // winning first move, c_done in second COMPUTE cycle
        do_turn(4'd5, 1, 1'b1);
        check("won_hmove", 32'(h_move), 5);
        check("won_round", 32'(round), 1);
        check("won_state", 32'(dbg_state), 32'(S_WON));
        tap_enter(4'd2);
        repeat (3) @(negedge clock);
        check("won_ignores_enter", 32'(h_move), 5);

        // illegal moves then a legal one
        press_new();
        t = cyc; push(K_BAD, 0, t + 1);
        tap_enter(4'd12);
        @(negedge clock);
        check("bad12_round", 32'(round), 0);
        check("bad12_state", 32'(dbg_state), 32'(S_WAIT_H));
        t = cyc; push(K_BAD, 0, t + 1);
        tap_enter(4'd10);
        @(negedge clock);
        do_turn(4'd3, 0, 1'b0);
        check("legal3_hmove", 32'(h_move), 3);
        check("legal3_round", 32'(round), 1);
        check("legal3_state", 32'(dbg_state), 32'(S_WAIT_H));

        // eight losing rounds
        press_new();
        for (int i = 0; i < 8; i++) do_turn(mv_tab[i], i % 3, 1'b0);
        check("lost_round", 32'(round), 8);
        check("lost_flag", 32'(game_lost), 1);
        check("lost_state", 32'(dbg_state), 32'(S_LOST));
        tap_enter(4'd1);
        repeat (3) @(negedge clock);
        check("lost_ignores_enter", 32'(dbg_state), 32'(S_LOST));
        press_new();
        check("lost_newgame_round", 32'(round), 0);
        check("lost_newgame_state", 32'(dbg_state), 32'(S_WAIT_H));

        // datapath timeout
        t = cyc; exp_round = 1;
        push(K_LOAD, 7, t + 1);
        push(K_CST, 1, t + 2);
        push(K_ERR, 1, t + 202);
        tap_enter(4'd7);
        wait_until(t + 204);
        check("timeout_error", 32'(error), 1);
        check("timeout_state", 32'(dbg_state), 32'(S_ERR));
        check("timeout_busy", 32'(busy), 0);
        c_done = 1'b1;
        @(negedge clock);
        c_done = 1'b0;
        @(negedge clock);
        check("err_ignores_cdone", 32'(dbg_state), 32'(S_ERR));

        // c_done in the last allowed COMPUTE cycle
        press_new();
        do_turn(4'd7, 199, 1'b0);
        check("lastcycle_error", 32'(error), 0);
        check("lastcycle_state", 32'(dbg_state), 32'(S_WAIT_H));
        check("lastcycle_round", 32'(round), 1);

        // held enter gives one press
        t = cyc; exp_round++;
        push(K_LOAD, 2, t + 1);
        push(K_CST, exp_round, t + 2);
        hMove = 4'd2; enter_L = 1'b0;
        wait_until(t + 2);
        c_done = 1'b1; win = 1'b0;
        @(negedge clock);
        c_done = 1'b0;
        wait_until(t + 50);
        enter_L = 1'b1;
        @(negedge clock);
        check("hold_round", 32'(round), 2);
        check("hold_state", 32'(dbg_state), 32'(S_WAIT_H));

        // reset during COMPUTE
        t = cyc; exp_round++;
        push(K_LOAD, 4, t + 1);
        push(K_CST, exp_round, t + 2);
        tap_enter(4'd4);
        wait_until(t + 3);
        reset = 1'b1;
        @(negedge clock);
        exp_round = 0;
        check("midreset_state", 32'(dbg_state), 32'(S_IDLE));
        check("midreset_round", 32'(round), 0);
        check("midreset_status", 32'(status()), 0);
        reset = 1'b0;
        c_done = 1'b1;
        @(negedge clock);
        c_done = 1'b0;
        repeat (5) @(negedge clock);
        check("midreset_stays_idle", 32'(dbg_state), 32'(S_IDLE));

        check("queue_drained", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/turn_sequencer.md
Name: turn_sequencer

Overview:
- Game-flow controller sitting between the synchronized pushbuttons and the guess/response datapath of the guessing game.
- Detects button presses and validates the human move.
- Latches the move, then starts the computer-move/compare datapath and waits for its completion with a timeout.
- Counts rounds and declares win, loss or error; the board top level drives LEDs and HEX from its status outputs.

Parameters:
- MAX_ROUNDS, 8, rounds allowed before loss (1..15)
- MAX_MOVE, 9, largest legal hMove value; hMove > MAX_MOVE is illegal
- TIMEOUT, 200, COMPUTE cycles allowed before error (2..1023)

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high reset
- newGame_L  input  1  synchronized new-game button, active low
- enter_L  input  1  synchronized enter button, active low
- hMove  input  4  human move switches
- c_done  input  1  datapath finished computing and comparing the current move
- win  input  1  datapath compare result, valid while c_done is high and held afterwards
- load_h  output  1  one-cycle strobe: datapath captures h_move
- h_move  output  4  registered accepted human move
- c_start  output  1  one-cycle strobe: datapath begins computer move and compare
- round  output  4  number of moves accepted this game
- busy  output  1  high in LATCH, COMPUTE and CHECK
- bad_move  output  1  one-cycle pulse: illegal move rejected
- game_won  output  1  high in WON
- game_lost  output  1  high in LOST
- error  output  1  high in ERR (datapath timeout)

Behaviour:
- Press detection
  - Registered previous values of enter_L and newGame_L; both reset to 1.
  - A press is prev=1 and current=0, one cycle per falling edge.
  - Holding a button produces no further presses.
- Reset (synchronous, active-high) sets:
  - state=IDLE, round=0, h_move=0, timeout counter=0.
  - All strobes and status outputs = 0.
- Reset asserted mid-operation aborts the turn the next edge. No c_start is issued afterwards.
- Priority: reset > newGame press > all other transitions.
  - A newGame press in any state sets state→WAIT_H, round→0, counter→0, and cancels any pending turn.
- States: IDLE, WAIT_H, LATCH, COMPUTE, CHECK, WON, LOST, ERR. All outputs are Moore outputs decoded from state except bad_move, which is registered.
- IDLE: ignores enter; waits for a newGame press.
- WAIT_H, on an enter press:
  - hMove ≤ MAX_MOVE: next state LATCH; h_move←hMove and round←round+1 on the same edge.
  - Otherwise: stay in WAIT_H; bad_move=1 for exactly the next cycle; round unchanged.
- LATCH: load_h=1 for one cycle; always → COMPUTE.
- COMPUTE:
  - c_start=1 only in the first COMPUTE cycle.
  - Counter clears on entry and increments each COMPUTE cycle.
  - c_done high (including the first cycle) → CHECK.
  - Counter reaches TIMEOUT with c_done low → ERR.
  - If c_done and timeout occur in the same cycle, c_done wins.
- CHECK: samples win.
  - win=1 → WON.
  - Else round==MAX_ROUNDS → LOST.
  - Else → WAIT_H.
- WON / LOST / ERR: terminal. Enter is ignored; only newGame or reset leaves.
- Enter presses during LATCH, COMPUTE or CHECK are discarded, not queued.
- Latency: enter press in cycle t gives:
  - t+1: load_h
  - t+2: c_start
  - earliest CHECK at t+3, if c_done is high in t+2
  - earliest WAIT_H or terminal state at t+4.
- round never wraps: the maximum value is MAX_ROUNDS because LOST is entered at that point.
- c_done outside COMPUTE is ignored.

Test Plan:
- Reset then newGame press → state WAIT_H, round=0, all strobes 0; enter press in IDLE before newGame → no load_h.
- WAIT_H, hMove=4'd5, enter press at t, c_done high at t+3, win=1 → load_h at t+1, h_move=5, c_start at t+2 only, round=1, game_won high from t+5.
- hMove=4'd12 with enter press → bad_move pulse one cycle, no load_h, round stays 0; then hMove=3 with a new press → accepted.
- Eight moves with win=0 (MAX_ROUNDS=8) → round=8, game_lost=1; a further enter press → no load_h; newGame press → round=0, WAIT_H.
- Enter press, c_done never asserted → error=1 after TIMEOUT=200 COMPUTE cycles; c_done raised exactly at cycle 200 in a rerun → CHECK, no error.
- Hold enter_L low 50 cycles → exactly one load_h; reset asserted during COMPUTE → next cycle IDLE, outputs 0, round=0.
